// File: rtl/text_console_writer.sv
// Byte-stream text console: tracks a cursor, writes code point/attribute cells into the
// text BRAM write port, and scrolls by rotating a circular physical-row offset.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// CLEAR_ALL | blank every cell, cursor and row offset parked at 0
// IDLE      | ready for a byte; printable bytes write one cell per cycle
// WRAP_PEND | auto-wrap scroll: lets the char write retire before the row clear
// CLEAR_ROW | blank the newly exposed bottom physical row, one cell per cycle
module text_console_writer #(
   parameter int unsigned COLS       = 160,
   parameter int unsigned ROWS       = 45,
   parameter logic [7:0]  CLEAR_ATTR = 8'h07
) (
   input  logic        clk_hdmi_in,
   input  logic        rst_in,
   input  logic        char_valid_in,
   input  logic [7:0]  char_in,
   input  logic [7:0]  attr_in,
   output logic        char_ready_out,
   output logic        wr_en_out,
   output logic [12:0] wr_addr_out,
   output logic [7:0]  wr_code_point_out,
   output logic [7:0]  wr_attribute_out,
   output logic [5:0]  row_offset_out,
   output logic [7:0]  cursor_x_out,
   output logic [5:0]  cursor_y_out
);

   localparam logic [12:0] CELLS_W  = 13'(COLS * ROWS);
   localparam logic [12:0] COLS_W   = 13'(COLS);
   localparam logic [7:0]  LAST_COL = 8'(COLS - 1);
   localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
   localparam logic [6:0]  ROWS_W7  = 7'(ROWS);
   localparam logic [7:0]  BLANK    = 8'h20;

   typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRAP_PEND, CLEAR_ROW} state_t;

   state_t      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [12:0] clr_base_q, clr_base_d;
   logic        ready_q, ready_d;
   logic        wr_en_q, wr_en_d;
   logic [12:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_cp_q, wr_cp_d;
   logic [7:0]  wr_attr_q, wr_attr_d;
   logic [5:0]  off_q, off_d;
   logic [7:0]  cx_q, cx_d;
   logic [5:0]  cy_q, cy_d;

   logic [6:0]  row_sum;
   logic [6:0]  phys_row;
   logic [12:0] cell_addr;
   logic [12:0] off_base;
   logic [5:0]  next_off;
   logic        accept;
   logic        printable;

   // Both operands are below ROWS, so one conditional subtract is the full modulo.
   always_comb begin
      row_sum   = {1'b0, cy_q} + {1'b0, off_q};
      phys_row  = (row_sum >= ROWS_W7) ? (row_sum - ROWS_W7) : row_sum;
      cell_addr = 13'(phys_row) * COLS_W + 13'(cx_q);
      off_base  = 13'(off_q) * COLS_W;
      next_off  = (off_q == LAST_ROW) ? 6'd0 : (off_q + 6'd1);
      accept    = char_valid_in && ready_q;
      printable = (char_in >= 8'h20) && (char_in != 8'h7F);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_base_d = clr_base_q;
      ready_d    = ready_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_cp_d    = wr_cp_q;
      wr_attr_d  = wr_attr_q;
      off_d      = off_q;
      cx_d       = cx_q;
      cy_d       = cy_q;

      case (state_q)
         CLEAR_ALL: begin
            cx_d  = 8'd0;
            cy_d  = 6'd0;
            off_d = 6'd0;
            if (cnt_q == CELLS_W) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_cp_d   = BLANK;
               wr_attr_d = CLEAR_ATTR;
               cnt_d     = cnt_q + 13'd1;
            end
         end

         IDLE: begin
            if (accept) begin
               case (char_in)
                  8'h0D: cx_d = 8'd0;
                  8'h08: if (cx_q != 8'd0) cx_d = cx_q - 8'd1;
                  8'h0A: begin
                     cx_d = 8'd0;
                     if (cy_q < LAST_ROW) begin
                        cy_d = cy_q + 6'd1;
                     end else begin
                        // The old top physical row becomes the new bottom row; clear it now.
                        off_d      = next_off;
                        clr_base_d = off_base;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = off_base;
                        wr_cp_d    = BLANK;
                        wr_attr_d  = CLEAR_ATTR;
                        cnt_d      = 13'd1;
                        state_d    = CLEAR_ROW;
                        ready_d    = 1'b0;
                     end
                  end
                  8'h0C: begin
                     cx_d      = 8'd0;
                     cy_d      = 6'd0;
                     off_d     = 6'd0;
                     wr_en_d   = 1'b1;
                     wr_addr_d = 13'd0;
                     wr_cp_d   = BLANK;
                     wr_attr_d = CLEAR_ATTR;
                     cnt_d     = 13'd1;
                     state_d   = CLEAR_ALL;
                     ready_d   = 1'b0;
                  end
                  default: begin
                     if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_cp_d   = char_in;
                        wr_attr_d = attr_in;
                        if (cx_q < LAST_COL) begin
                           cx_d = cx_q + 8'd1;
                        end else begin
                           cx_d = 8'd0;
                           if (cy_q < LAST_ROW) begin
                              cy_d = cy_q + 6'd1;
                           end else begin
                              off_d      = next_off;
                              clr_base_d = off_base;
                              state_d    = WRAP_PEND;
                              ready_d    = 1'b0;
                           end
                        end
                     end
                  end
               endcase
            end
         end

         WRAP_PEND: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_base_q;
            wr_cp_d   = BLANK;
            wr_attr_d = CLEAR_ATTR;
            cnt_d     = 13'd1;
            state_d   = CLEAR_ROW;
         end

         CLEAR_ROW: begin
            if (cnt_q == COLS_W) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = clr_base_q + cnt_q;
               wr_cp_d   = BLANK;
               wr_attr_d = CLEAR_ATTR;
               cnt_d     = cnt_q + 13'd1;
            end
         end

         default: begin
            state_d = CLEAR_ALL;
            cnt_d   = 13'd0;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_hdmi_in) begin
      if (rst_in) begin
         state_q    <= CLEAR_ALL;
         cnt_q      <= 13'd0;
         clr_base_q <= 13'd0;
         ready_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 13'd0;
         wr_cp_q    <= 8'd0;
         wr_attr_q  <= 8'd0;
         off_q      <= 6'd0;
         cx_q       <= 8'd0;
         cy_q       <= 6'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_base_q <= clr_base_d;
         ready_q    <= ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_cp_q    <= wr_cp_d;
         wr_attr_q  <= wr_attr_d;
         off_q      <= off_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
      end
   end

   assign char_ready_out    = ready_q;
   assign wr_en_out         = wr_en_q;
   assign wr_addr_out       = wr_addr_q;
   assign wr_code_point_out = wr_cp_q;
   assign wr_attribute_out  = wr_attr_q;
   assign row_offset_out    = off_q;
   assign cursor_x_out      = cx_q;
   assign cursor_y_out      = cy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: scoreboard of expected BRAM writes plus a vector table
// of single-byte effects and hand-written wrap/scroll/reset sequences.
module tb_text_console_writer;

   logic        clk_hdmi_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        char_valid_in = 1'b0;
   logic [7:0]  char_in = 8'h00;
   logic [7:0]  attr_in = 8'h00;
   logic        char_ready_out;
   logic        wr_en_out;
   logic [12:0] wr_addr_out;
   logic [7:0]  wr_code_point_out;
   logic [7:0]  wr_attribute_out;
   logic [5:0]  row_offset_out;
   logic [7:0]  cursor_x_out;
   logic [5:0]  cursor_y_out;

   text_console_writer dut (
      .clk_hdmi_in       (clk_hdmi_in),
      .rst_in            (rst_in),
      .char_valid_in     (char_valid_in),
      .char_in           (char_in),
      .attr_in           (attr_in),
      .char_ready_out    (char_ready_out),
      .wr_en_out         (wr_en_out),
      .wr_addr_out       (wr_addr_out),
      .wr_code_point_out (wr_code_point_out),
      .wr_attribute_out  (wr_attribute_out),
      .row_offset_out    (row_offset_out),
      .cursor_x_out      (cursor_x_out),
      .cursor_y_out      (cursor_y_out)
   );

   always #5 clk_hdmi_in = ~clk_hdmi_in;

   int n_tests = 0;
   int n_fail  = 0;
   logic        mon_en = 1'b0;
   logic [28:0] exp_q[$];
   logic [28:0] mon_e;
   int          moff = 0;

   typedef struct {
      logic [7:0]  ch;
      logic [7:0]  at;
      logic        wr;
      logic [12:0] addr;
      logic [7:0]  cx;
      logic [5:0]  cy;
   } vec_t;
   vec_t vecs[13];

   always @(negedge clk_hdmi_in) begin
      if (mon_en && wr_en_out) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %02h/%02h, no write required",
                     wr_addr_out, wr_code_point_out, wr_attribute_out);
         end else begin
            mon_e = exp_q.pop_front();
            if ({wr_addr_out, wr_code_point_out, wr_attribute_out} !== mon_e) begin
               n_fail++;
               $display("FAIL write: got addr %0d data %02h/%02h, required addr %0d data %02h/%02h",
                        wr_addr_out, wr_code_point_out, wr_attribute_out,
                        mon_e[28:16], mon_e[15:8], mon_e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_w(input int addr, input logic [7:0] cp, input logic [7:0] at);
      exp_q.push_back({13'(addr), cp, at});
   endtask

   task automatic push_clear_all();
      for (int i = 0; i < 7200; i++) push_w(i, 8'h20, 8'h07);
      moff = 0;
   endtask

   // Scroll model: the current top physical row is cleared and becomes the bottom row.
   task automatic push_scroll();
      for (int k = 0; k < 160; k++) push_w(moff * 160 + k, 8'h20, 8'h07);
      moff = (moff == 44) ? 0 : moff + 1;
   endtask

   task automatic wait_ready(input int max_cycles);
      int n;
      n = 0;
      while (!char_ready_out && n < max_cycles) begin
         @(posedge clk_hdmi_in); #1;
         n++;
      end
      if (!char_ready_out) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: ready %0d after %0d cycles, required 1", char_ready_out, n);
      end
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] a);
      wait_ready(9000);
      char_valid_in = 1'b1;
      char_in       = c;
      attr_in       = a;
      @(posedge clk_hdmi_in); #1;
      char_valid_in = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"},  32'(wr_en_out), 0);
      chk({tag, "_ready"},  32'(char_ready_out), 0);
      chk({tag, "_addr"},   32'(wr_addr_out), 0);
      chk({tag, "_cursor"}, 32'({cursor_x_out, cursor_y_out}), 0);
      chk({tag, "_offset"}, 32'(row_offset_out), 0);
   endtask

   task automatic finish_clear(input string tag);
      wait_ready(8000);
      chk({tag, "_all_written"}, 32'(exp_q.size()), 0);
      chk({tag, "_cursor_x"}, 32'(cursor_x_out), 0);
      chk({tag, "_cursor_y"}, 32'(cursor_y_out), 0);
      chk({tag, "_offset"}, 32'(row_offset_out), 0);
   endtask

   initial begin
      int cnt;
      vecs[0]  = '{8'h41, 8'h1F, 1'b1, 13'd0,   8'd1, 6'd0};
      vecs[1]  = '{8'h62, 8'h2E, 1'b1, 13'd1,   8'd2, 6'd0};
      vecs[2]  = '{8'h08, 8'h00, 1'b0, 13'd0,   8'd1, 6'd0};
      vecs[3]  = '{8'h0D, 8'h00, 1'b0, 13'd0,   8'd0, 6'd0};
      vecs[4]  = '{8'h08, 8'h00, 1'b0, 13'd0,   8'd0, 6'd0};
      vecs[5]  = '{8'h0A, 8'h00, 1'b0, 13'd0,   8'd0, 6'd1};
      vecs[6]  = '{8'h01, 8'h33, 1'b0, 13'd0,   8'd0, 6'd1};
      vecs[7]  = '{8'h7F, 8'h33, 1'b0, 13'd0,   8'd0, 6'd1};
      vecs[8]  = '{8'h7E, 8'h70, 1'b1, 13'd160, 8'd1, 6'd1};
      vecs[9]  = '{8'h20, 8'h05, 1'b1, 13'd161, 8'd2, 6'd1};
      vecs[10] = '{8'h1B, 8'h00, 1'b0, 13'd0,   8'd2, 6'd1};
      vecs[11] = '{8'h0A, 8'h00, 1'b0, 13'd0,   8'd0, 6'd2};
      vecs[12] = '{8'hFF, 8'h44, 1'b1, 13'd320, 8'd1, 6'd2};

      // Power-up reset and full clear
      repeat (2) @(posedge clk_hdmi_in);
      #1;
      check_reset_outputs("reset");
      rst_in = 1'b0;
      push_clear_all();
      mon_en = 1'b1;
      finish_clear("init_clear");

      // Single-byte vectors from (0,0); 'A' also checks latency and back-to-back readiness
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) push_w(int'(vecs[i].addr), vecs[i].ch, vecs[i].at);
         send(vecs[i].ch, vecs[i].at);
         chk($sformatf("vec%0d_wr_en", i), 32'(wr_en_out), 32'(vecs[i].wr));
         if (vecs[i].wr) chk($sformatf("vec%0d_addr", i), 32'(wr_addr_out), 32'(vecs[i].addr));
         chk($sformatf("vec%0d_cursor_x", i), 32'(cursor_x_out), 32'(vecs[i].cx));
         chk($sformatf("vec%0d_cursor_y", i), 32'(cursor_y_out), 32'(vecs[i].cy));
         chk($sformatf("vec%0d_ready", i), 32'(char_ready_out), 1);
      end

      // Form feed clears everything again
      push_clear_all();
      send(8'h0C, 8'h00);
      chk("ff_ready_low", 32'(char_ready_out), 0);
      finish_clear("ff_clear");

      // 161 printable bytes: wrap after column 159
      for (int i = 0; i < 161; i++) begin
         push_w(i, 8'h30 + 8'(i % 10), 8'(i));
         send(8'h30 + 8'(i % 10), 8'(i));
         if (i == 159) begin
            chk("wrap_cursor_x", 32'(cursor_x_out), 0);
            chk("wrap_cursor_y", 32'(cursor_y_out), 1);
         end
      end
      chk("after161_cursor_x", 32'(cursor_x_out), 1);
      chk("after161_cursor_y", 32'(cursor_y_out), 1);

      // Move to (5,44) and scroll with LF
      send(8'h0D, 8'h00);
      for (int i = 0; i < 43; i++) send(8'h0A, 8'h00);
      chk("bottom_cursor_y", 32'(cursor_y_out), 44);
      for (int i = 0; i < 5; i++) begin
         push_w(7040 + i, 8'h78, 8'h0E);
         send(8'h78, 8'h0E);
      end
      chk("pre_lf_cursor_x", 32'(cursor_x_out), 5);
      push_scroll();
      send(8'h0A, 8'h00);
      chk("lf_scroll_offset", 32'(row_offset_out), 1);
      chk("lf_scroll_cursor_x", 32'(cursor_x_out), 0);
      chk("lf_scroll_cursor_y", 32'(cursor_y_out), 44);
      cnt = 0;
      while (!char_ready_out && cnt < 1000) begin
         cnt++;
         @(posedge clk_hdmi_in); #1;
      end
      chk("lf_scroll_ready_low_cycles", 32'(cnt), 160);

      // Scroll until offset 44, fill row to column 159, then wrap-scroll with 'Z'
      for (int i = 0; i < 43; i++) begin
         push_scroll();
         send(8'h0A, 8'h00);
      end
      wait_ready(1000);
      chk("offset44", 32'(row_offset_out), 44);
      for (int i = 0; i < 159; i++) begin
         push_w(43 * 160 + i, 8'h2E, 8'h02);
         send(8'h2E, 8'h02);
      end
      chk("pre_z_cursor_x", 32'(cursor_x_out), 159);
      push_w(43 * 160 + 159, 8'h5A, 8'h4F);
      push_scroll();
      send(8'h5A, 8'h4F);
      chk("z_wr_en", 32'(wr_en_out), 1);
      chk("z_addr", 32'(wr_addr_out), 7039);
      chk("z_offset", 32'(row_offset_out), 0);
      chk("z_cursor_x", 32'(cursor_x_out), 0);
      chk("z_cursor_y", 32'(cursor_y_out), 44);
      chk("z_ready_low", 32'(char_ready_out), 0);
      @(posedge clk_hdmi_in); #1;
      chk("z_first_clear_addr", 32'(wr_addr_out), 7040);
      wait_ready(1000);
      chk("z_clear_done", 32'(exp_q.size()), 0);

      // Backspace at column 0: no write, cursor unchanged
      send(8'h08, 8'h00);
      chk("bs_col0_wr_en", 32'(wr_en_out), 0);
      chk("bs_col0_cursor_x", 32'(cursor_x_out), 0);
      chk("bs_col0_cursor_y", 32'(cursor_y_out), 44);

      // Reset in the middle of a row clear restarts the full clear
      push_scroll();
      send(8'h0A, 8'h00);
      repeat (20) @(posedge clk_hdmi_in);
      #1;
      chk("mid_clear_row_busy", 32'(char_ready_out), 0);
      mon_en = 1'b0;
      rst_in = 1'b1;
      repeat (2) @(posedge clk_hdmi_in);
      #1;
      check_reset_outputs("mid_reset");
      exp_q.delete();
      rst_in = 1'b0;
      push_clear_all();
      mon_en = 1'b1;
      finish_clear("reclear");

      repeat (5) @(posedge clk_hdmi_in);
      #1;
      chk("final_queue_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
